// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage and IF/ID pipeline register
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          IM_AW    = 10,
   // ROM contents built from code.txt; word i lives at bits [32*i +: 32]
   parameter logic [32*(2**IM_AW)-1:0] ROM_IMAGE = '0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_f,
   input  logic        flush_d,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pc_f,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc4_d,
   output logic        valid_d,
   output logic        addr_fault
);

   // ROM span in bytes; one extra bit so the compare cannot wrap
   localparam logic [32:0] ROM_BYTES = 33'(4) << IM_AW;

   logic [31:0]      pc_offset;
   logic [31:0]      pc_plus4;
   logic [IM_AW-1:0] rom_index;
   logic             fetch_legal;
   logic [31:0]      rom_word;

   // combinational ROM read; an illegal fetch supplies a nop
   always_comb begin
      pc_offset   = pc_f - RESET_PC;
      pc_plus4    = pc_f + 32'd4;
      rom_index   = pc_offset[IM_AW+1:2];
      fetch_legal = (pc_f[1:0] == 2'b00) && ({1'b0, pc_offset} < ROM_BYTES);
      rom_word    = fetch_legal ? ROM_IMAGE[{rom_index, 5'b0} +: 32] : 32'h0000_0000;
   end

   // program counter: stall holds, redirect is dropped while stalled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_f <= RESET_PC;
      end else if (!stall_f) begin
         if (redirect) begin
            pc_f <= redirect_pc;
         end else begin
            pc_f <= pc_plus4;
         end
      end
   end

   // IF/ID register; stall beats flush, redirect leaves the delay slot alone
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_d <= 32'h0;
         pc_d    <= 32'h0;
         pc4_d   <= 32'h0;
         valid_d <= 1'b0;
      end else if (!stall_f) begin
         if (flush_d) begin
            instr_d <= 32'h0;
            pc_d    <= 32'h0;
            pc4_d   <= 32'h0;
            valid_d <= 1'b0;
         end else begin
            instr_d <= rom_word;
            pc_d    <= pc_f;
            pc4_d   <= pc_plus4;
            valid_d <= 1'b1;
         end
      end
   end

   // sticky fault flag, only an unstalled illegal fetch sets it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_fault <= 1'b0;
      end else if (!stall_f && !fetch_legal) begin
         addr_fault <= 1'b1;
      end
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register for the pipelined `mips` core. It holds the program counter and reads the instruction ROM, which is initialised from `code.txt`. It steps the PC by 4 or takes a branch/jump redirect from decode. It delivers `{instr, pc, pc+4, valid}` to the decode stage one cycle after fetch. Stall and flush requests come from the hazard unit.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset; also the ROM base address.
- `IM_AW`, 10, ROM word-address width; depth is 2^IM_AW 32-bit words.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `stall_f`  in  1  hold the PC and the IF/ID register this cycle.
- `flush_d`  in  1  load a bubble into IF/ID this cycle.
- `redirect`  in  1  decode resolved a taken branch or jump.
- `redirect_pc`  in  32  target address for `redirect`.
- `pc_f`  out  32  current fetch PC.
- `instr_d`  out  32  IF/ID instruction.
- `pc_d`  out  32  IF/ID PC of `instr_d`.
- `pc4_d`  out  32  IF/ID `pc_d + 4`.
- `valid_d`  out  1  IF/ID holds a real instruction; 0 marks a bubble.
- `addr_fault`  out  1  sticky flag: a fetch address was misaligned or outside the ROM.

## Operation
- ROM index = `(pc_f - RESET_PC) >> 2`, truncated to IM_AW bits. The ROM read is combinational.
- A fetch is legal when `pc_f[1:0] == 0` and `pc_f - RESET_PC < 4*2^IM_AW`, using unsigned 32-bit arithmetic.
- An illegal fetch supplies instruction 32'h0000_0000 (nop) and sets `addr_fault` on that edge, unless `stall_f` is high. `addr_fault` is cleared only by reset.
- Next-PC priority, highest first:
  - reset → `RESET_PC`
  - `stall_f` → hold
  - `redirect` → `redirect_pc`
  - otherwise → `pc_f + 4`, wrapping modulo 2^32.
- IF/ID load priority, highest first:
  - reset → bubble (all zeros)
  - `stall_f` → hold
  - `flush_d` → bubble (instr 0, pc 0, pc4 0, valid 0)
  - otherwise → `{rom_word, pc_f, pc_f+4, 1}`.
- Branch delay slot: on `redirect`, the instruction fetched in the same cycle is the delay slot. It enters IF/ID normally. `redirect` does not flush.
- `stall_f` with `redirect`: the redirect is ignored. Decode holds the branch and reasserts `redirect` on the next unstalled cycle.
- `stall_f` with `flush_d`: the stall wins and IF/ID is held.
- `redirect_pc` is not checked on capture. A bad target shows up as an illegal fetch on the following cycle.

## Timing
- Reset values: `pc_f` = `RESET_PC`; `instr_d`, `pc_d` and `pc4_d` = 0; `valid_d` = 0; `addr_fault` = 0.
- Fetch-to-decode latency is 1 cycle: the word at `pc_f` during cycle n appears on `instr_d` after edge n.
- A redirect asserted in cycle n sets `pc_f` to the target after edge n. The target instruction reaches `instr_d` after edge n+1.
- A stall freezes all registers for exactly the stalled cycles, with no slip: the first unstalled cycle continues from the held PC.
- Reset asserted mid-operation: outputs return to reset values immediately, without waiting for a clock edge. After reset is released, the first edge fetches from `RESET_PC`.
- Throughput is one instruction per cycle when there is no stall.

## Test plan
- Reset release with ROM words 0..3 = 0x3C01_0001, 0x3421_0002, 0x0000_0000, 0x1000_FFFF → `instr_d` shows these words on edges 1–4. `pc_d` steps 0x3000, 0x3004, 0x3008, 0x300C. `valid_d` = 1 from edge 1.
- `redirect` = 1 with `redirect_pc` = 0x3010 in the cycle that fetches 0x3008 → `instr_d` shows 0x3008 (delay slot), then 0x3010.
- `stall_f` held for 3 cycles while `pc_f` = 0x3004 → `pc_f` and IF/ID unchanged for 3 edges. The next edge loads 0x3004.
- `flush_d` for 1 cycle → one bubble (`valid_d` = 0, `instr_d` = 0) with no PC skip. `stall_f` and `flush_d` together → IF/ID held.
- `redirect_pc` = 0x3002, then separately 0x0000_0000 → each gives `instr_d` = 0 and `addr_fault` = 1. The flag stays set until reset.
- Reset pulsed mid-run between edges → all outputs return to reset values immediately. The fetch sequence restarts at 0x3000.
